// File: rtl/circular_op_stepper.sv
// circular_op_stepper
//   Walks a circular arc one unit step at a time. Each move goes along a single
//   axis, and the stepper picks whichever candidate keeps the point closest to
//   the true circle.
//
//   State | Meaning
//   ------+-------------------------------------------------------------
//   IDLE  | start_rdy=1, waiting for arc parameters
//   INIT  | compute err = x^2 + y^2 - r^2 for the start point
//   STEP  | present one move per handshake until steps_left reaches 0
//   DONE  | one-cycle done pulse, then back to IDLE
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   start_valid / start_rdy    : arc-parameter handshake
//   is_cw, start_x, start_y, r : direction, start point relative to center, radius
//   num_steps                  : number of unit moves to emit
//   out_valid / out_rdy        : move handshake toward the step-output stage
//   out_axis, out_neg          : move axis (0=X, 1=Y) and direction (1 = -1)
//   out_x, out_y               : position after the presented move
//   steps_left                 : moves remaining, including the one presented
//   done                       : one-cycle pulse after the last move is accepted
module circular_op_stepper #(
  parameter  int NUM_BITS  = 8,
  localparam int STEP_BITS = NUM_BITS + 3,
  localparam int ERR_BITS  = 2 * NUM_BITS + 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_valid,
  output logic                        start_rdy,
  input  logic                        is_cw,
  input  logic signed [NUM_BITS-1:0]  start_x,
  input  logic signed [NUM_BITS-1:0]  start_y,
  input  logic        [NUM_BITS-1:0]  r,
  input  logic        [STEP_BITS-1:0] num_steps,
  output logic                        out_valid,
  input  logic                        out_rdy,
  output logic                        out_axis,
  output logic                        out_neg,
  output logic signed [NUM_BITS-1:0]  out_x,
  output logic signed [NUM_BITS-1:0]  out_y,
  output logic        [STEP_BITS-1:0] steps_left,
  output logic                        done
);

  typedef enum logic [1:0] {IDLE, INIT, STEP, DONE} state_t;

  state_t                      state_q, state_d;
  logic                        cw_q;
  logic signed [NUM_BITS-1:0]  cur_x, cur_y;
  logic        [NUM_BITS-1:0]  r_q;
  logic signed [ERR_BITS-1:0]  err_q;
  logic        [STEP_BITS-1:0] steps_q;

  logic signed [ERR_BITS-1:0]  x_e, y_e, r_e, err_init;
  logic signed [ERR_BITS-1:0]  e_x, e_y, e_sel;
  logic        [ERR_BITS-1:0]  abs_x, abs_y;
  logic                        x_pos, x_neg, x_zero, y_pos, y_neg, y_zero;
  logic                        neg_x, neg_y, sel_y;
  logic signed [NUM_BITS-1:0]  tgt_x, tgt_y;

  always_comb begin
    x_e = {{(ERR_BITS-NUM_BITS){cur_x[NUM_BITS-1]}}, cur_x};
    y_e = {{(ERR_BITS-NUM_BITS){cur_y[NUM_BITS-1]}}, cur_y};
    r_e = {{(ERR_BITS-NUM_BITS){1'b0}}, r_q};
    err_init = x_e * x_e + y_e * y_e - r_e * r_e;

    x_neg  = cur_x[NUM_BITS-1];
    x_zero = (cur_x == '0);
    x_pos  = !x_neg && !x_zero;
    y_neg  = cur_y[NUM_BITS-1];
    y_zero = (cur_y == '0);
    y_pos  = !y_neg && !y_zero;

    // Counter-clockwise candidate directions per quadrant; origin counts as Q1.
    if ((x_pos && !y_neg) || (x_zero && y_zero)) begin
      neg_x = 1'b1; neg_y = 1'b0;
    end else if (!x_pos && y_pos) begin
      neg_x = 1'b1; neg_y = 1'b1;
    end else if (x_neg && !y_pos) begin
      neg_x = 1'b0; neg_y = 1'b1;
    end else begin
      neg_x = 1'b0; neg_y = 1'b0;
    end
    if (cw_q) begin
      neg_x = !neg_x;
      neg_y = !neg_y;
    end

    // (a +/- 1)^2 - a^2 = +/-2a + 1, so each candidate error is an increment on err.
    e_x = err_q + (neg_x ? -(x_e + x_e) : (x_e + x_e)) + ERR_BITS'(1);
    e_y = err_q + (neg_y ? -(y_e + y_e) : (y_e + y_e)) + ERR_BITS'(1);
    abs_x = e_x[ERR_BITS-1] ? -e_x : e_x;
    abs_y = e_y[ERR_BITS-1] ? -e_y : e_y;

    if (abs_x < abs_y)      sel_y = 1'b0;
    else if (abs_x > abs_y) sel_y = 1'b1;
    else if (e_x == e_y)    sel_y = 1'b0;
    else                    sel_y = e_x[ERR_BITS-1];  // equal magnitude: take the e>=0 side

    e_sel = sel_y ? e_y : e_x;
    tgt_x = sel_y ? cur_x : cur_x + {{(NUM_BITS-1){neg_x}}, 1'b1};
    tgt_y = sel_y ? cur_y + {{(NUM_BITS-1){neg_y}}, 1'b1} : cur_y;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_valid) state_d = INIT;
      INIT: state_d = (steps_q == '0) ? DONE : STEP;
      STEP: if (out_rdy && steps_q == STEP_BITS'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cw_q    <= 1'b0;
      cur_x   <= '0;
      cur_y   <= '0;
      r_q     <= '0;
      err_q   <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start_valid) begin
          cw_q    <= is_cw;
          cur_x   <= start_x;
          cur_y   <= start_y;
          r_q     <= r;
          steps_q <= num_steps;
        end
        INIT: err_q <= err_init;
        STEP: if (out_rdy) begin
          cur_x   <= tgt_x;
          cur_y   <= tgt_y;
          err_q   <= e_sel;
          steps_q <= steps_q - STEP_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  // Move outputs are held at zero outside STEP so the idle bus is quiet.
  assign start_rdy  = (state_q == IDLE);
  assign out_valid  = (state_q == STEP);
  assign done       = (state_q == DONE);
  assign out_axis   = out_valid && sel_y;
  assign out_neg    = out_valid && (sel_y ? neg_y : neg_x);
  assign out_x      = out_valid ? tgt_x : '0;
  assign out_y      = out_valid ? tgt_y : '0;
  assign steps_left = steps_q;

endmodule

// File: tb/tb_circular_op_stepper.sv
module tb_circular_op_stepper;
  localparam int NUM_BITS  = 8;
  localparam int STEP_BITS = NUM_BITS + 3;

  logic clk = 1'b0;
  logic reset, start_valid, start_rdy, is_cw, out_valid, out_rdy;
  logic out_axis, out_neg, done;
  logic signed [NUM_BITS-1:0] start_x, start_y, out_x, out_y;
  logic [NUM_BITS-1:0]  r;
  logic [STEP_BITS-1:0] num_steps, steps_left;

  int errors = 0;
  int checks = 0;
  int last_x, last_y;

  circular_op_stepper #(.NUM_BITS(NUM_BITS)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_rdy(start_rdy),
    .is_cw(is_cw), .start_x(start_x), .start_y(start_y), .r(r),
    .num_steps(num_steps), .out_valid(out_valid), .out_rdy(out_rdy),
    .out_axis(out_axis), .out_neg(out_neg), .out_x(out_x), .out_y(out_y),
    .steps_left(steps_left), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: choose the single-axis unit move whose landing point has the
  // smallest |x^2 + y^2 - r^2|; ties go to the non-negative error, then to X.
  function automatic void model_step(input int x, input int y, input int rr, input bit cw,
                                     output bit axis, output bit neg);
    int sx, sy, ex, ey, aex, aey;
    if ((x > 0 && y >= 0) || (x == 0 && y == 0)) begin sx = -1; sy = 1; end
    else if (x <= 0 && y > 0) begin sx = -1; sy = -1; end
    else if (x < 0 && y <= 0) begin sx = 1; sy = -1; end
    else begin sx = 1; sy = 1; end
    if (cw) begin sx = -sx; sy = -sy; end
    ex = (x + sx) * (x + sx) + y * y - rr * rr;
    ey = x * x + (y + sy) * (y + sy) - rr * rr;
    aex = (ex < 0) ? -ex : ex;
    aey = (ey < 0) ? -ey : ey;
    if (aex < aey)      axis = 1'b0;
    else if (aex > aey) axis = 1'b1;
    else if (ex == ey)  axis = 1'b0;
    else                axis = (ex >= 0) ? 1'b0 : 1'b1;
    neg = axis ? (sy < 0) : (sx < 0);
  endfunction

  // mode 0: out_rdy always high; 1: out_rdy low 3 cycles on the first move;
  // 2: random out_rdy plus start_valid noise while busy.
  task automatic run_arc(input bit cw, input int sx, input int sy, input int rr,
                         input int n, input int mode);
    int x, y, tx, ty, acc, cyc, stalls;
    bit ax, ng, rdy;
    @(negedge clk);
    chk("idle_start_rdy", int'(start_rdy), 1);
    is_cw = cw; start_x = sx[NUM_BITS-1:0]; start_y = sy[NUM_BITS-1:0];
    r = rr[NUM_BITS-1:0]; num_steps = n[STEP_BITS-1:0];
    start_valid = 1'b1; out_rdy = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    cyc = 1;
    chk("init_start_rdy", int'(start_rdy), 0);
    chk("init_out_valid", int'(out_valid), 0);
    x = sx; y = sy; acc = 0; stalls = 0;
    while (acc < n) begin
      @(negedge clk);
      cyc++;
      model_step(x, y, rr, cw, ax, ng);
      tx = ax ? x : (ng ? x - 1 : x + 1);
      ty = ax ? (ng ? y - 1 : y + 1) : y;
      chk("out_valid", int'(out_valid), 1);
      chk("out_axis", int'(out_axis), int'(ax));
      chk("out_neg", int'(out_neg), int'(ng));
      chk("out_x", int'(out_x), tx);
      chk("out_y", int'(out_y), ty);
      chk("steps_left", int'(steps_left), n - acc);
      chk("done_low", int'(done), 0);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = !(acc == 0 && stalls < 3);
        default: rdy = ($urandom_range(0, 2) != 0) || (stalls > 4 * n + 8);
      endcase
      out_rdy = rdy;
      if (mode == 2) begin
        start_valid = $urandom_range(0, 1) == 1;
        start_x = NUM_BITS'($urandom);
        start_y = NUM_BITS'($urandom);
      end
      if (rdy) begin x = tx; y = ty; acc++; end
      else stalls++;
    end
    @(negedge clk);
    cyc++;
    out_rdy = 1'b0; start_valid = 1'b0;
    chk("done_pulse", int'(done), 1);
    chk("done_out_valid", int'(out_valid), 0);
    chk("done_cycle", cyc, n + 2 + stalls);
    chk("done_start_rdy", int'(start_rdy), 0);
    @(negedge clk);
    chk("done_cleared", int'(done), 0);
    chk("rdy_after_done", int'(start_rdy), 1);
    last_x = x; last_y = y;
  endtask

  initial begin
    reset = 1'b1; start_valid = 1'b0; out_rdy = 1'b0; is_cw = 1'b0;
    start_x = '0; start_y = '0; r = '0; num_steps = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_axis", int'(out_axis), 0);
    chk("rst_out_neg", int'(out_neg), 0);
    chk("rst_out_x", int'(out_x), 0);
    chk("rst_out_y", int'(out_y), 0);
    chk("rst_steps_left", int'(steps_left), 0);
    chk("rst_start_rdy", int'(start_rdy), 1);

    // Quarter arcs from the directed plan, then the full r=1 circle.
    run_arc(1'b0, 2, 0, 2, 4, 0);
    chk("ccw_end_x", last_x, 0);
    chk("ccw_end_y", last_y, 2);
    run_arc(1'b1, 0, 2, 2, 4, 0);
    chk("cw_end_x", last_x, 2);
    chk("cw_end_y", last_y, 0);
    run_arc(1'b0, 1, 0, 1, 8, 0);
    chk("circle_end_x", last_x, 1);
    chk("circle_end_y", last_y, 0);

    // Backpressure on the first move, and a zero-length arc.
    run_arc(1'b0, 2, 0, 2, 4, 1);
    run_arc(1'b0, 3, 0, 3, 0, 0);

    // Reset after two of four moves are accepted.
    @(negedge clk);
    is_cw = 1'b0; start_x = 8'sd2; start_y = 8'sd0; r = 8'd2; num_steps = 11'd4;
    start_valid = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("pre_reset_steps", int'(steps_left), 2);
    reset = 1'b1; out_rdy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_steps_left", int'(steps_left), 0);
    chk("mid_rst_start_rdy", int'(start_rdy), 1);
    @(negedge clk);
    chk("post_rst_done", int'(done), 0);
    run_arc(1'b1, 0, 2, 2, 4, 0);
    chk("fresh_end_x", last_x, 2);
    chk("fresh_end_y", last_y, 0);

    // Random arcs from an axis point of the circle.
    for (int i = 0; i < 24; i++) begin
      int rr, pos, n, sx, sy;
      bit cw;
      rr = $urandom_range(1, 20);
      pos = $urandom_range(0, 3);
      cw = $urandom_range(0, 1) == 1;
      n = $urandom_range(0, 8 * rr);
      sx = (pos == 0) ? rr : (pos == 2) ? -rr : 0;
      sy = (pos == 1) ? rr : (pos == 3) ? -rr : 0;
      run_arc(cw, sx, sy, rr, n, (i % 3 == 0) ? 0 : 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/circular_op_stepper.md
# circular_op_stepper

Walks a circular arc one unit step at a time, producing the per-step move sequence for a circular plotter command. It consumes the parameters of an arc: start point relative to the center, radius, direction, and the total step count from the circular-op step calculator. It emits exactly that many single-axis unit moves over a valid/ready handshake toward the motor/step-output stage. Each move is chosen to stay closest to the true circle.

## Interface
Parameters:
- NUM_BITS, default 8 (`BYTE_BITS`): width of signed coordinates and radius.
- STEP_BITS, localparam, NUM_BITS+3: width of the step count (max 8·r).
- ERR_BITS, localparam, 2·NUM_BITS+3: width of the signed circle-error register.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: synchronous, active-high.
- start_valid, input, 1: the arc parameters are valid.
- start_rdy, output, 1: the block is idle and can accept an arc.
- is_cw, input, 1: 1 = clockwise, 0 = counter-clockwise.
- start_x, input, NUM_BITS: signed start X, relative to the center.
- start_y, input, NUM_BITS: signed start Y, relative to the center.
- r, input, NUM_BITS: radius (non-negative).
- num_steps, input, STEP_BITS: total unit moves to emit.
- out_valid, output, 1: a move is presented.
- out_rdy, input, 1: the consumer accepts the presented move.
- out_axis, output, 1: 0 = X move, 1 = Y move.
- out_neg, output, 1: 1 = move −1, 0 = move +1.
- out_x, output, NUM_BITS: signed X after the presented move.
- out_y, output, NUM_BITS: signed Y after the presented move.
- steps_left, output, STEP_BITS: moves remaining, including the one presented.
- done, output, 1: one-cycle pulse after the last move is accepted.

## Operation
- FSM states: IDLE, INIT, STEP, DONE.
- IDLE:
  - start_rdy=1.
  - On start_valid & start_rdy at an edge: latch is_cw, start_x→cur_x, start_y→cur_y, r, num_steps→steps_left; go to INIT.
- INIT:
  - err = cur_x² + cur_y² − r², computed in ERR_BITS signed arithmetic.
  - steps_left==0 → DONE; otherwise → STEP.
- Quadrants:
  - Q1: x>0, y≥0.
  - Q2: x≤0, y>0.
  - Q3: x<0, y≤0.
  - Q4: x≥0, y<0.
- Candidate moves:
  - CCW: Q1 {x−1, y+1}; Q2 {x−1, y−1}; Q3 {x+1, y−1}; Q4 {x+1, y+1}.
  - CW: each sign is inverted.
- Move error: a move of s∈{±1} on axis a gives e_a = err + 2·s·a + 1.
- Move selection:
  - Pick the candidate with smaller |e|.
  - If |e_x|==|e_y|, pick the candidate with e≥0.
  - If e_x==e_y, pick X.
- STEP:
  - out_valid=1, presenting the selected move; out_x/out_y show the target position.
  - On out_valid & out_rdy at an edge: cur←target, err←chosen e, steps_left−1.
  - If steps_left was 1 → DONE; otherwise stay in STEP.
  - Presented outputs stay stable while out_rdy=0.
- DONE: done=1 for one cycle, then → IDLE.
- Origin (x=y=0) is not in any quadrant: treat it as Q1. The step calculator never requests steps at r=0.
- Coordinates never wrap in legal use (|x|,|y|≤r). No saturation is applied.
- reset in any state: the block goes to IDLE at that edge, any in-flight arc is dropped, and no done pulse is produced.

## Timing
- Reset values:
  - state IDLE.
  - out_valid=0, done=0.
  - out_axis=0, out_neg=0.
  - out_x=0, out_y=0, steps_left=0.
  - start_rdy=1 from the first cycle after reset is sampled.
- Accept at edge N: INIT during cycle N+1; first out_valid during cycle N+2.
- With out_rdy held high: one move per cycle, and out_valid stays high continuously.
- Last move accepted at edge M: done=1 in cycle M+1; start_rdy=1 in cycle M+2.
- num_steps=0, accepted at edge N: done=1 in cycle N+2; out_valid is never asserted.
- start_valid during INIT, STEP or DONE is ignored (start_rdy=0).

## Test plan
- r=2, start (2,0), CCW, num_steps=4, out_rdy=1:
  - Moves, in order: Y+ (2,1), X− (1,1), Y+ (1,2), X− (0,2).
  - steps_left goes 4,3,2,1; done follows the last move by one cycle.
- r=2, start (0,2), CW, num_steps=4:
  - Moves, in order: X+ (1,2), Y− (1,1), X+ (2,1), Y− (2,0).
- r=1, start (1,0), CCW, num_steps=8 (full circle, exercises tie-break):
  - Positions: (1,1), (0,1), (−1,1), (−1,0), (−1,−1), (0,−1), (1,−1), (1,0).
  - The path ends back at the start point.
- Backpressure: in the first scenario, drop out_rdy for 3 cycles after the first move is presented.
  - out_valid, out_axis, out_neg, out_x, out_y and steps_left stay stable.
  - The move sequence is unchanged; done is delayed 3 cycles.
- num_steps=0, start (3,0), r=3:
  - out_valid never asserts; done pulses 2 cycles after accept; start_rdy returns 1 a cycle later.
- Reset mid-arc: assert reset for 1 cycle after 2 of 4 moves are accepted.
  - Next cycle: out_valid=0, done=0, steps_left=0, start_rdy=1.
  - A fresh arc then runs correctly from its own start point.
